// File: rtl/alu_sequencer_if.sv
// Request/response, ALU and debug signals between the sequencer and its environment.
// slave = the sequencer itself, master = whoever issues requests and supplies the ALU.
interface alu_sequencer_if #(parameter int ADDR_W = 3);
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_cmd;
  logic [6:0]        req_opm;
  logic [ADDR_W-1:0] req_ra;
  logic [ADDR_W-1:0] req_rb;
  logic [ADDR_W-1:0] req_rd;
  logic              req_imm_sel;
  logic [63:0]       req_imm;
  logic [4:0]        alu_cmd;
  logic [6:0]        alu_opm;
  logic [63:0]       alu_a;
  logic [63:0]       alu_b;
  logic [63:0]       alu_out;
  logic [63:0]       alu_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_data;
  logic [63:0]       rsp_flags;
  logic [ADDR_W-1:0] rsp_rd;
  logic [ADDR_W-1:0] dbg_addr;
  logic [63:0]       dbg_data;

  modport slave (
    input  req_valid, req_cmd, req_opm, req_ra, req_rb, req_rd, req_imm_sel, req_imm,
    output req_ready,
    output alu_cmd, alu_opm, alu_a, alu_b,
    input  alu_out, alu_flags,
    output rsp_valid, rsp_data, rsp_flags, rsp_rd,
    input  rsp_ready,
    input  dbg_addr,
    output dbg_data
  );

  modport master (
    output req_valid, req_cmd, req_opm, req_ra, req_rb, req_rd, req_imm_sel, req_imm,
    input  req_ready,
    input  alu_cmd, alu_opm, alu_a, alu_b,
    output alu_out, alu_flags,
    input  rsp_valid, rsp_data, rsp_flags, rsp_rd,
    output rsp_ready,
    output dbg_addr,
    input  dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU command initiator: reads operands from a local register file, issues one op
// to a combinational ALU, writes the result back and returns it on a response channel.
module alu_sequencer #(
  parameter int          ADDR_W     = 3,
  parameter logic [63:0] FLAGS_MASK = 64'h71F7F,
  parameter logic [4:0]  IDLE_CMD   = 5'd3,
  parameter logic [4:0]  INIT_CMD   = 5'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            state;
  logic [63:0]       regs [NREG];
  logic [ADDR_W-1:0] rd_q;
  logic [63:0]       rd_a, rd_b, rd_dbg;

  // R0 is hardwired to zero on every read port
  assign rd_a   = (bus.req_ra   == '0) ? 64'd0 : regs[bus.req_ra];
  assign rd_b   = (bus.req_rb   == '0) ? 64'd0 : regs[bus.req_rb];
  assign rd_dbg = (bus.dbg_addr == '0) ? 64'd0 : regs[bus.dbg_addr];
  assign bus.dbg_data = rd_dbg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_INIT;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      rd_q          <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_flags <= '0;
      bus.rsp_rd    <= '0;
      bus.alu_cmd   <= INIT_CMD;
      bus.alu_opm   <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
    end else begin
      case (state)
        // One cycle of LOADFLAG with a=0 clears the ALU flags
        S_INIT: begin
          bus.alu_cmd   <= IDLE_CMD;
          bus.req_ready <= 1'b1;
          state         <= S_IDLE;
        end
        S_IDLE: begin
          if (bus.req_valid) begin
            bus.alu_cmd   <= bus.req_cmd;
            bus.alu_opm   <= bus.req_opm;
            bus.alu_a     <= rd_a;
            bus.alu_b     <= bus.req_imm_sel ? bus.req_imm : rd_b;
            rd_q          <= bus.req_rd;
            bus.req_ready <= 1'b0;
            state         <= S_ISSUE;
          end
        end
        // ALU has settled on the issued operands; capture and drop back to PASSFLAG
        S_ISSUE: begin
          bus.rsp_data  <= bus.alu_out;
          bus.rsp_flags <= bus.alu_flags & FLAGS_MASK;
          bus.rsp_rd    <= rd_q;
          bus.rsp_valid <= 1'b1;
          bus.alu_cmd   <= IDLE_CMD;
          if (rd_q != '0) regs[rd_q] <= bus.alu_out;
          state         <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, register-file reference and a response scoreboard.
module tb_alu_sequencer;
  localparam logic [4:0]  C_OR  = 5'd12;
  localparam logic [4:0]  C_ADD = 5'd20;
  localparam logic [4:0]  C_SUB = 5'd22;
  localparam logic [63:0] MASK  = 64'h71F7F;

  typedef struct {
    logic [63:0] data;
    logic [63:0] flags;
    logic [2:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.ADDR_W(3)) bus();
  alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t        sb[$];
  logic [63:0] ref_r [8];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] d, f;

  // Bit 63 and bit 7 are always set so the flag mask is exercised
  function automatic logic [127:0] alu_fn(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r, fl;
    s = '0;
    case (c)
      C_OR:    r = a | b;
      C_ADD:   begin s = {1'b0, a} + {1'b0, b}; r = s[63:0]; end
      C_SUB:   begin s = {1'b0, a} - {1'b0, b}; r = s[63:0]; end
      default: r = a;
    endcase
    fl = '0;
    fl[63] = 1'b1;
    fl[7]  = 1'b1;
    fl[9]  = r[63];
    fl[11] = (r == 64'd0);
    fl[17] = s[64];
    return {fl, r};
  endfunction

  always_comb {bus.alu_flags, bus.alu_out} = alu_fn(bus.alu_cmd, bus.alu_a, bus.alu_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic dbg(input logic [2:0] addr, input logic [63:0] exp);
    bus.dbg_addr = addr;
    #1;
    chk($sformatf("dbg_r%0d", addr), bus.dbg_data, exp);
  endtask

  task automatic send(input logic [4:0] cmd, input logic [6:0] opm, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [2:0] rd, input logic imm_sel,
                      input logic [63:0] imm, input bit drop);
    int t;
    logic [63:0] a, b, o, fl;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
    if (!bus.req_ready) begin chk("req_ready_timeout", 0, 1); return; end
    a = (ra == 0) ? 64'd0 : ref_r[ra];
    b = imm_sel ? imm : ((rb == 0) ? 64'd0 : ref_r[rb]);
    bus.req_cmd = cmd; bus.req_opm = opm; bus.req_ra = ra; bus.req_rb = rb;
    bus.req_rd = rd; bus.req_imm_sel = imm_sel; bus.req_imm = imm;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (drop) return;
    {fl, o} = alu_fn(cmd, a, b);
    e.data = o; e.flags = fl & MASK; e.rd = rd;
    sb.push_back(e);
    if (rd != 0) ref_r[rd] = o;
    @(negedge clk);
    chk("issue_cmd", bus.alu_cmd, cmd);
    chk("issue_opm", bus.alu_opm, opm);
    chk("issue_a", bus.alu_a, a);
    chk("issue_b", bus.alu_b, b);
  endtask

  task automatic collect(input int hold, output logic [63:0] od, output logic [63:0] of);
    int t;
    logic [63:0] sd, sf;
    exp_t e;
    od = '0; of = '0;
    t = 0;
    while (!bus.rsp_valid && t < 20) begin @(negedge clk); t++; end
    if (!bus.rsp_valid) begin chk("rsp_valid_timeout", 0, 1); return; end
    sd = bus.rsp_data; sf = bus.rsp_flags;
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = i[0] ? 1'b0 : 1'b1;
      bus.req_rd = 3'd7; bus.req_imm_sel = 1'b1; bus.req_imm = 64'hDEAD;
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_data", bus.rsp_data, sd);
      chk("hold_flags", bus.rsp_flags, sf);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    if (sb.size() == 0) begin chk("sb_empty", 1, 0); return; end
    e = sb.pop_front();
    chk("rsp_data", bus.rsp_data, e.data);
    chk("rsp_flags", bus.rsp_flags, e.flags);
    chk("rsp_rd", bus.rsp_rd, e.rd);
    od = bus.rsp_data; of = bus.rsp_flags;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", bus.rsp_valid, 0);
    chk("back_idle", bus.req_ready, 1);
  endtask

  task automatic release_and_check_init();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("init_cmd", bus.alu_cmd, 5'd4);
    chk("init_a", bus.alu_a, 0);
    chk("init_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("idle_cmd", bus.alu_cmd, 5'd3);
    chk("idle_ready", bus.req_ready, 1);
    chk("idle_rsp_valid", bus.rsp_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    bus.req_valid = 0; bus.req_cmd = 0; bus.req_opm = 0; bus.req_ra = 0; bus.req_rb = 0;
    bus.req_rd = 0; bus.req_imm_sel = 0; bus.req_imm = 0; bus.rsp_ready = 0; bus.dbg_addr = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", bus.alu_cmd, 5'd4);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    release_and_check_init();

    send(C_OR, 7'd0, 3'd0, 3'd0, 3'd1, 1'b1, 64'd10, 0);  collect(0, d, f);
    send(C_OR, 7'd0, 3'd0, 3'd0, 3'd2, 1'b1, -64'sd15, 0); collect(0, d, f);
    send(C_ADD, 7'h15, 3'd1, 3'd2, 3'd3, 1'b0, 64'd0, 0); collect(0, d, f);
    chk("add_const", d, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("add_neg_flag", f[9], 1);
    chk("add_zero_flag", f[11], 0);
    chk("mask_bits", f & ~MASK, 0);
    dbg(3'd3, 64'hFFFF_FFFF_FFFF_FFFB);

    send(C_SUB, 7'd0, 3'd1, 3'd1, 3'd4, 1'b0, 64'd0, 0); collect(0, d, f);
    chk("sub_const", d, 0);
    chk("sub_zero_flag", f[11], 1);
    chk("sub_carry_flag", f[17], 0);

    send(C_OR, 7'd0, 3'd1, 3'd0, 3'd5, 1'b1, 64'd3, 0); collect(5, d, f);
    dbg(3'd5, 64'd11);
    dbg(3'd7, 64'd0);

    send(C_OR, 7'd0, 3'd0, 3'd0, 3'd0, 1'b1, 64'd5, 0); collect(0, d, f);
    chk("r0_rsp_data", d, 64'd5);
    dbg(3'd0, 64'd0);

    // dependent back-to-back chain reads the freshly written value
    send(C_ADD, 7'd0, 3'd1, 3'd0, 3'd1, 1'b1, 64'd1, 0); collect(0, d, f);
    send(C_ADD, 7'd0, 3'd1, 3'd0, 3'd1, 1'b1, 64'd1, 0); collect(0, d, f);
    dbg(3'd1, 64'd12);

    send(C_ADD, 7'd0, 3'd1, 3'd0, 3'd3, 1'b1, 64'd100, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_cmd", bus.alu_cmd, 5'd4);
    chk("midrst_ready", bus.req_ready, 0);
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    @(posedge clk);
    release_and_check_init();
    dbg(3'd3, 64'd0);
    dbg(3'd1, 64'd0);
    send(C_ADD, 7'd0, 3'd0, 3'd0, 3'd6, 1'b1, 64'd7, 0); collect(0, d, f);
    dbg(3'd6, 64'd7);
    dbg(3'd3, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
